// File: rtl/frame_proc_core_if.sv
// rtl/frame_proc_core_if.sv - mem0/mem1 and control signal bundle for frame_proc_core
interface frame_proc_core_if #(
   parameter int ADDR_W = 19
);
   logic [1:0]        mode;
   logic              freeze;
   logic [7:0]        din;
   logic [ADDR_W-1:0] addr_mem0;
   logic [ADDR_W-1:0] addr_mem1;
   logic [3:0]        dout;
   logic              we;
   logic              busy;
   logic              frame_done;

   modport master (
      output mode, freeze, din,
      input  addr_mem0, addr_mem1, dout, we, busy, frame_done
   );

   modport slave (
      input  mode, freeze, din,
      output addr_mem0, addr_mem1, dout, we, busy, frame_done
   );
endinterface

// File: rtl/frame_proc_core.sv
// rtl/frame_proc_core.sv - streams frames mem0 -> mem1 as pass, threshold or KxK box-average downscale
module frame_proc_core #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int ADDR_W     = 19,
   parameter int SCALE_LOG2 = 2,
   parameter int RD_LAT     = 2,
   parameter int THRESH     = 128
) (
   input  logic              clk25,
   input  logic              rst_n,
   frame_proc_core_if.slave  bus
);
   localparam int K     = 1 << SCALE_LOG2;
   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int ACC_W = 8 + 2 * SCALE_LOG2;
   localparam int NBLK  = WIDTH / K;
   localparam int IW    = (NBLK > 1) ? $clog2(NBLK) : 1;

   localparam logic [ADDR_W-1:0]     W_A      = ADDR_W'(WIDTH);
   localparam logic [ADDR_W-1:0]     LAST_A   = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [XW-1:0]         X_LAST   = XW'(WIDTH - 1);
   localparam logic [YW-1:0]         Y_LAST   = YW'(HEIGHT - 1);
   localparam logic [SCALE_LOG2-1:0] SUB_LAST = '1;
   localparam logic [7:0]            TH_8     = 8'(THRESH);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;

   state_t            r_state;
   logic [1:0]        r_cur_mode;
   logic [1:0]        r_last_mode;
   logic              r_iv;
   logic [XW-1:0]     r_ix;
   logic [YW-1:0]     r_iy;
   logic [RD_LAT-1:0] r_pv;
   logic [XW-1:0]     r_px [RD_LAT];
   logic [YW-1:0]     r_py [RD_LAT];
   logic              r_last_wr;
   logic [ADDR_W-1:0] r_addr0;
   logic [ADDR_W-1:0] r_addr1;
   logic [3:0]        r_dout;
   logic              r_we;
   logic              r_busy;
   logic              r_done;
   logic [ACC_W-1:0]  r_acc [NBLK];

   // Tail of the read pipeline: this pixel's din is valid in the current cycle.
   logic              w_v;
   logic [XW-1:0]     w_x;
   logic [YW-1:0]     w_y;
   logic              w_blk_first;
   logic              w_blk_last;
   logic              w_is_last;
   logic [IW-1:0]     w_idx;
   logic [ACC_W-1:0]  w_sum;
   logic [ADDR_W-1:0] w_src_addr;
   logic [ADDR_W-1:0] w_ds_addr;
   logic [3:0]        w_thr;

   assign w_v         = r_pv[RD_LAT-1];
   assign w_x         = r_px[RD_LAT-1];
   assign w_y         = r_py[RD_LAT-1];
   assign w_blk_first = (w_x[SCALE_LOG2-1:0] == '0) && (w_y[SCALE_LOG2-1:0] == '0);
   assign w_blk_last  = (w_x[SCALE_LOG2-1:0] == SUB_LAST) && (w_y[SCALE_LOG2-1:0] == SUB_LAST);
   assign w_is_last   = w_v && (w_x == X_LAST) && (w_y == Y_LAST);
   assign w_idx       = IW'(w_x >> SCALE_LOG2);
   assign w_sum       = r_acc[w_idx] + ACC_W'(bus.din);
   assign w_src_addr  = ADDR_W'(w_y) * W_A + ADDR_W'(w_x);
   assign w_ds_addr   = ADDR_W'(w_y >> SCALE_LOG2) * W_A + ADDR_W'(w_x >> SCALE_LOG2);
   assign w_thr       = (bus.din >= TH_8) ? 4'hF : 4'h0;

   // Accumulator contents are only meaningful after the first pixel of each block loads them.
   always_ff @(posedge clk25) begin
      if (w_v && (r_cur_mode == 2'd2)) begin
         r_acc[w_idx] <= w_blk_first ? ACC_W'(bus.din) : w_sum;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cur_mode  <= 2'd0;
         r_last_mode <= 2'd0;
         r_iv        <= 1'b0;
         r_ix        <= '0;
         r_iy        <= '0;
         r_pv        <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_px[i] <= '0;
            r_py[i] <= '0;
         end
         r_last_wr   <= 1'b0;
         r_addr0     <= '0;
         r_addr1     <= '0;
         r_dout      <= 4'h0;
         r_we        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_we      <= 1'b0;
         r_done    <= 1'b0;
         r_last_wr <= 1'b0;

         r_pv[0] <= r_iv;
         r_px[0] <= r_ix;
         r_py[0] <= r_iy;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_px[i] <= r_px[i-1];
            r_py[i] <= r_py[i-1];
         end

         if (w_v) begin
            r_last_wr <= w_is_last;
            case (r_cur_mode)
               2'd2: begin
                  if (w_blk_last) begin
                     r_we    <= 1'b1;
                     r_addr1 <= w_ds_addr;
                     r_dout  <= w_sum[ACC_W-1 -: 4];
                  end
               end
               2'd1: begin
                  r_we    <= 1'b1;
                  r_addr1 <= w_src_addr;
                  r_dout  <= w_thr;
               end
               default: begin
                  r_we    <= 1'b1;
                  r_addr1 <= w_src_addr;
                  r_dout  <= bus.din[7:4];
               end
            endcase
         end

         case (r_state)
            S_IDLE: begin
               if (!bus.freeze) begin
                  r_cur_mode <= bus.mode;
                  r_busy     <= 1'b1;
                  if ((bus.mode == 2'd2) && (r_last_mode != 2'd2)) begin
                     r_state <= S_CLEAR;
                     r_we    <= 1'b1;
                     r_addr1 <= '0;
                     r_dout  <= 4'h0;
                  end else begin
                     r_state <= S_RUN;
                     r_iv    <= 1'b1;
                     r_ix    <= '0;
                     r_iy    <= '0;
                     r_addr0 <= '0;
                  end
               end
            end
            S_CLEAR: begin
               if (r_addr1 == LAST_A) begin
                  r_state <= S_RUN;
                  r_iv    <= 1'b1;
                  r_ix    <= '0;
                  r_iy    <= '0;
                  r_addr0 <= '0;
               end else begin
                  r_we    <= 1'b1;
                  r_addr1 <= r_addr1 + 1'b1;
                  r_dout  <= 4'h0;
               end
            end
            S_RUN: begin
               if (r_iv) begin
                  if ((r_ix == X_LAST) && (r_iy == Y_LAST)) begin
                     r_iv <= 1'b0;
                  end else begin
                     if (r_ix == X_LAST) begin
                        r_ix <= '0;
                        r_iy <= r_iy + 1'b1;
                     end else begin
                        r_ix <= r_ix + 1'b1;
                     end
                     r_addr0 <= r_addr0 + 1'b1;
                  end
               end
               // The final pixel's write is on the bus this cycle; close the pass.
               if (r_last_wr) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_last_mode <= r_cur_mode;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.addr_mem0  = r_addr0;
   assign bus.addr_mem1  = r_addr1;
   assign bus.dout       = r_dout;
   assign bus.we         = r_we;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_done;
endmodule

// File: doc/frame_proc_core.md
Name: frame_proc_core

Overview:
- Parametrised successor to the fixed 640x480 frame-processing core between the capture BRAM (mem0, 8-bit grey) and the VGA framebuffer (mem1, 4-bit).
- Streams whole frames from mem0 to mem1 continuously in one of three modes: passthrough, threshold binarise, or KxK box-average downscale into the top-left of mem1.
- Runs in the clk25 domain and replaces the hard-wired resolution-change path used for lenet input.

Parameters:
- WIDTH, 640, frame width in pixels; also the mem1 row stride.
- HEIGHT, 480, frame height in lines.
- ADDR_W, 19, address width of both memory ports.
- SCALE_LOG2, 2, downscale factor K = 2^SCALE_LOG2. Legal range 1..3. WIDTH and HEIGHT must be divisible by K.
- RD_LAT, 2, mem0 read latency in cycles from addr_mem0 to valid din. Legal range 1..3.
- THRESH, 128, threshold-mode compare level.

Ports:
- clk25  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  0 pass, 1 threshold, 2 downscale, 3 treated as pass
- freeze  in  1  hold at frame boundary (pause image)
- din  in  8  mem0 read data
- addr_mem0  out  ADDR_W  mem0 read address
- addr_mem1  out  ADDR_W  mem1 write address
- dout  out  4  mem1 write data
- we  out  1  mem1 write enable
- busy  out  1  high while a CLEAR or RUN pass is active
- frame_done  out  1  one-cycle pulse after the last write of a RUN pass

Behaviour:
- Reset (async, rst_n low):
  - All outputs go to 0, state goes to IDLE, accumulators are don't-care, last_mode is set to 0.
  - Reset mid-frame aborts immediately: we drops with the reset, nothing is flushed, and the next pass starts at address 0.
- States:
  - IDLE: on any cycle with freeze=0, latch mode into cur_mode. If cur_mode=2 and last_mode!=2, go to CLEAR; otherwise go to RUN. freeze=1 holds IDLE.
  - CLEAR: writes dout=0, we=1 to addresses 0..WIDTH*HEIGHT-1, one per cycle. mem0 is not read. Then go to RUN.
  - RUN: issues addr_mem0 = y*WIDTH+x in raster order, one per cycle, with no stalls. After the last issued address drains through the pipeline, pulse frame_done, set last_mode=cur_mode, and return to IDLE. Back-to-back frames therefore have exactly one IDLE cycle between them.
- Mode and freeze are sampled only in IDLE. Changes mid-pass are ignored until the next boundary. freeze asserted mid-pass lets the current pass complete.
- busy=1 in CLEAR and RUN, 0 in IDLE.
- Pipeline:
  - A shift register of depth RD_LAT carries (valid, x, y) alongside each read.
  - Output registers (we, addr_mem1, dout) are loaded from din in the cycle it is valid.
  - A write therefore appears RD_LAT+1 cycles after its address was issued.
  - frame_done is asserted in the cycle after the final we=1.
- Pass mode: dout = din[7:4], addr_mem1 = the matching source address, one write per pixel.
- Threshold mode: dout = 4'hF if din >= THRESH, else 4'h0. Same addressing as pass mode.
- Downscale mode:
  - Row accumulator buffer: WIDTH/K entries, each 8+2*SCALE_LOG2 bits, indexed by x>>SCALE_LOG2.
  - When x%K==0 and y%K==0, the entry is loaded with din; otherwise din is added to it.
  - When x%K==K-1 and y%K==K-1, write once:
    - sum = entry + din, formed without overflow;
    - avg = sum >> (2*SCALE_LOG2), truncating;
    - dout = avg[7:4];
    - addr_mem1 = (y>>SCALE_LOG2)*WIDTH + (x>>SCALE_LOG2).
  - No other writes occur. mem1 outside the (WIDTH/K)x(HEIGHT/K) region keeps its CLEAR value.
- Address arithmetic is done in ADDR_W bits. x wraps at WIDTH-1 and y increments. The last pixel is x=WIDTH-1, y=HEIGHT-1.

Test Plan:
- Pass, WIDTH=8, HEIGHT=4, RD_LAT=2: mem0[i]=(i*16)&8'hFF. Required: mem1[i]=i%16 for i=0..31; first we 3 cycles after the first addr_mem0; exactly 32 writes; frame_done in the cycle after write 32; next frame starts 1 IDLE cycle later.
- Threshold: din sequence 127, 128, 0, 255. Required: dout 0, F, 0, F.
- Downscale, SCALE_LOG2=1, 8x4, last_mode=0: Required: first a CLEAR pass of 32 zero writes. Then, with the 2x2 block at mem0[0], mem0[1], mem0[8], mem0[9] = 8'h10, 8'h30, 8'h50, 8'h70, a single write of dout=4 at addr 0. Exactly 8 writes in the RUN pass, at addresses 0-3 and 8-11. A second downscale frame has no CLEAR.
- Freeze: assert freeze mid-RUN. Required: the frame completes, frame_done pulses, busy=0, the block stays in IDLE. Deassert freeze: busy rises 1 cycle later and addr_mem0=0.
- Mode change from 0 to 1 at mid-frame. Required: the rest of the frame is still pass data; the next frame is thresholded.
- Reset mid-RUN at pixel 13. Required: we=0 and busy=0 asynchronously. After release, the pass restarts at addr_mem0=0, and a downscale mode selected afterwards performs a CLEAR pass.
